pc_ras: RTL and testbench
=========================

Name: pc_ras

Overview:
- Next-generation program counter for the RISC core fetch stage, parametrised in address width.
- Supports relative jumps, absolute jumps, fetch stall and halt.
- Adds a hardware return-address stack (RAS) for call/return.
- Drives instruction-memory address prog_ctr; control decoder supplies enables and target.

Parameters:
WIDTH, 12, address width of prog_ctr, target and stack entries
RAS_DEPTH, 4, number of return-address stack entries (>=2, power of two)
RESET_ADDR, 0, value loaded into prog_ctr on reset

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
stall  input  1  hold PC and stack this cycle (pipeline bubble)
reljump_en  input  1  prog_ctr <= prog_ctr + target
absjump_en  input  1  prog_ctr <= target
call_en  input  1  push prog_ctr+1, prog_ctr <= target
ret_en  input  1  pop top of stack into prog_ctr
halt_en  input  1  enter HALTED state
target  input  WIDTH  jump offset (two's complement) or absolute address
prog_ctr  output  WIDTH  current fetch address
ras_count  output  $clog2(RAS_DEPTH)+1  valid stack entries, 0..RAS_DEPTH
ras_overflow  output  1  sticky: a call was made with stack full
ras_underflow  output  1  sticky: a return was made with stack empty
halted  output  1  high in HALTED state

Behaviour:
- Reset (reset==0, asynchronous): prog_ctr=RESET_ADDR, ras_count=0, ras_overflow=0, ras_underflow=0, halted=0, state RUN. Stack contents are don't-care. Reset asserted mid-operation overrides everything immediately.
- States:
  - RUN: normal operation.
  - HALTED: prog_ctr, stack and flags frozen; all inputs ignored; exit only via reset.
- In RUN with stall=1: no state change, regardless of the other enables. Stall overrides halt_en.
- In RUN with stall=0, apply the first matching rule, one update per cycle (zero-latency effect visible after the edge):
  1. halt_en: halted<=1 and enter HALTED; prog_ctr holds.
  2. ret_en:
     - If ras_count>0: prog_ctr<=top entry; ras_count-1.
     - Else: ras_underflow<=1; prog_ctr<=prog_ctr+1.
  3. call_en:
     - Push prog_ctr+1 (mod 2^WIDTH); prog_ctr<=target (absolute).
     - If ras_count==RAS_DEPTH: the oldest entry is overwritten (circular buffer), ras_count stays RAS_DEPTH, ras_overflow<=1.
  4. reljump_en: prog_ctr<=prog_ctr+target, modulo 2^WIDTH (target as unsigned add, so negative offsets wrap correctly).
  5. absjump_en: prog_ctr<=target.
  6. Otherwise: prog_ctr<=prog_ctr+1, wrapping from 2^WIDTH-1 to 0.
- Stack implementation:
  - Circular array of RAS_DEPTH entries with top pointer; pointer wraps modulo RAS_DEPTH.
  - Pop after an overflow returns the most recent RAS_DEPTH addresses in LIFO order.
- Flags: ras_overflow and ras_underflow are sticky until reset.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset/increment: RESET_ADDR=0; release reset, 5 idle cycles -> prog_ctr 1,2,3,4,5; assert reset asynchronously mid-cycle -> prog_ctr=0 before next edge.
- Relative/absolute/wrap (WIDTH=12):
  - At pc=0x010, reljump target=0xFFE (-2) -> 0x00E.
  - absjump target=0xFFF, then idle -> 0xFFF then 0x000.
- Call/return nesting:
  - At pc=0x020, call target=0x100 -> pc=0x100, ras_count=1.
  - At pc=0x105, call target=0x200 -> pc=0x200, ras_count=2.
  - ret -> 0x106; ret -> 0x021; ras_count=0, no flags set.
- Overflow/underflow (RAS_DEPTH=4):
  - 5 calls from pcs 0x001..0x005 (targets = next caller pc) -> ras_overflow=1, ras_count=4.
  - 4 rets -> 0x006,0x005,0x004,0x003.
  - 5th ret -> ras_underflow=1, pc=previous+1.
- Priority/stall:
  - ret_en+call_en+reljump_en same cycle -> only ret taken.
  - stall=1 with call_en -> pc and ras_count unchanged.
- Halt: halt_en at pc=0x030 -> halted=1, pc stays 0x030 for 10 cycles despite jumps/calls; reset -> halted=0, pc=RESET_ADDR.

Source files
------------

// File: rtl/pc_ras_if.sv
// Fetch-control bundle between the control decoder and the program counter.
interface pc_ras_if #(
  parameter int WIDTH     = 12,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH) + 1;

  logic             stall;
  logic             reljump_en;
  logic             absjump_en;
  logic             call_en;
  logic             ret_en;
  logic             halt_en;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] prog_ctr;
  logic [CW-1:0]    ras_count;
  logic             ras_overflow;
  logic             ras_underflow;
  logic             halted;

  // Decoder side: drives controls, observes the fetch address and stack status.
  modport master (
    output stall, reljump_en, absjump_en, call_en, ret_en, halt_en, target,
    input  prog_ctr, ras_count, ras_overflow, ras_underflow, halted
  );

  // Program-counter side.
  modport slave (
    input  stall, reljump_en, absjump_en, call_en, ret_en, halt_en, target,
    output prog_ctr, ras_count, ras_overflow, ras_underflow, halted
  );
endinterface

// File: rtl/pc_ras.sv
// Fetch-stage program counter with a circular return-address stack.
// One update per cycle, chosen by fixed priority: halt, ret, call, rel, abs, inc.
module pc_ras #(
  parameter int WIDTH      = 12,
  parameter int RAS_DEPTH  = 4,
  parameter int RESET_ADDR = 0
) (
  input  logic     clk,
  input  logic     reset,
  pc_ras_if.slave  bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]    FULL   = CW'(RAS_DEPTH);
  localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_ADDR);

  typedef enum logic {RUN, HALTED} state_t;

  state_t                          state_q, state_d;
  logic [WIDTH-1:0]                pc_q, pc_d, pc_inc;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [PW-1:0]                   top_q, top_d, push_ptr;
  logic                            ovf_q, ovf_d;
  logic                            unf_q, unf_d;
  logic [RAS_DEPTH-1:0][WIDTH-1:0] stack_q, stack_d;

  // Next-state selection; a full stack simply wraps the push pointer onto the oldest entry.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    top_d    = top_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    stack_d  = stack_q;
    pc_inc   = pc_q + WIDTH'(1);
    push_ptr = top_q + PW'(1);
    if (state_q == RUN && !bus.stall) begin
      if (bus.halt_en) begin
        state_d = HALTED;
      end else if (bus.ret_en) begin
        if (cnt_q != '0) begin
          pc_d  = stack_q[top_q];
          top_d = top_q - PW'(1);
          cnt_d = cnt_q - CW'(1);
        end else begin
          unf_d = 1'b1;
          pc_d  = pc_inc;
        end
      end else if (bus.call_en) begin
        stack_d[push_ptr] = pc_inc;
        top_d             = push_ptr;
        pc_d              = bus.target;
        if (cnt_q == FULL) ovf_d = 1'b1;
        else               cnt_d = cnt_q + CW'(1);
      end else if (bus.reljump_en) begin
        pc_d = pc_q + bus.target;
      end else if (bus.absjump_en) begin
        pc_d = bus.target;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  // Control state, PC, pointer and sticky flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RST_PC;
      cnt_q   <= '0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      top_q   <= top_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Stack storage; contents are meaningless until pushed, so no reset.
  always_ff @(posedge clk) begin
    stack_q <= stack_d;
  end

  assign bus.prog_ctr      = pc_q;
  assign bus.ras_count     = cnt_q;
  assign bus.ras_overflow  = ovf_q;
  assign bus.ras_underflow = unf_q;
  assign bus.halted        = (state_q == HALTED);
endmodule

// File: tb/tb_pc_ras.sv
// Directed plus randomized bench for pc_ras against a queue-based model.
module tb_pc_ras;
  localparam int W = 12;
  localparam int D = 4;
  localparam int M = 1 << W;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  pc_ras_if #(.WIDTH(W), .RAS_DEPTH(D)) bus();
  pc_ras #(.WIDTH(W), .RAS_DEPTH(D), .RESET_ADDR(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: return addresses live in a queue, newest at the back.
  int m_pc;
  int m_q[$];
  bit m_ovf, m_unf, m_halt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_q.delete(); m_ovf = 0; m_unf = 0; m_halt = 0;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".pc"},  32'(bus.prog_ctr), 32'(m_pc));
    chk({tag, ".cnt"}, 32'(bus.ras_count), 32'(m_q.size()));
    chk({tag, ".ovf"}, 32'(bus.ras_overflow), 32'(m_ovf));
    chk({tag, ".unf"}, 32'(bus.ras_underflow), 32'(m_unf));
    chk({tag, ".hlt"}, 32'(bus.halted), 32'(m_halt));
  endtask

  // Drive one cycle of controls, advance model, compare after the edge.
  task automatic drive(input string tag, input bit st, rl, ab, cl, rt, hl, input int tg);
    bus.stall = st; bus.reljump_en = rl; bus.absjump_en = ab;
    bus.call_en = cl; bus.ret_en = rt; bus.halt_en = hl; bus.target = W'(tg);
    @(posedge clk); #1;
    if (!m_halt && !st) begin
      if (hl) m_halt = 1;
      else if (rt) begin
        if (m_q.size() > 0) m_pc = m_q.pop_back();
        else begin m_unf = 1; m_pc = (m_pc + 1) % M; end
      end else if (cl) begin
        m_q.push_back((m_pc + 1) % M);
        if (m_q.size() > D) begin void'(m_q.pop_front()); m_ovf = 1; end
        m_pc = tg % M;
      end else if (rl) m_pc = (m_pc + tg) % M;
      else if (ab) m_pc = tg % M;
      else m_pc = (m_pc + 1) % M;
    end
    chk_all(tag);
  endtask

  task automatic idle(input string tag);  drive(tag, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic jmp(input int tg);        drive("abs", 0, 0, 1, 0, 0, 0, tg); endtask

  // Asynchronous reset mid-cycle; outputs must clear before the next edge.
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #3;
    model_reset();
    chk_all(tag);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  int exp_ret[4] = '{'h006, 'h005, 'h004, 'h003};

  initial begin
    bus.stall = 0; bus.reljump_en = 0; bus.absjump_en = 0;
    bus.call_en = 0; bus.ret_en = 0; bus.halt_en = 0; bus.target = '0;
    model_reset();
    #12;
    chk_all("rst");
    reset = 1'b1;

    // Increment after reset, then asynchronous reset.
    for (int i = 1; i <= 5; i++) begin
      idle("inc");
      chk("inc_const", 32'(bus.prog_ctr), 32'(i));
    end
    do_reset("arst");

    // Relative with negative offset, absolute to top and wrap.
    jmp('h010);
    drive("rel", 0, 1, 0, 0, 0, 0, 'hFFE);
    chk("rel_neg", 32'(bus.prog_ctr), 32'h00E);
    jmp('hFFF);
    idle("wrap");
    chk("wrap0", 32'(bus.prog_ctr), 32'h000);

    // Nested call/return.
    jmp('h020);
    drive("call1", 0, 0, 0, 1, 0, 0, 'h100);
    for (int i = 0; i < 5; i++) idle("body1");
    drive("call2", 0, 0, 0, 1, 0, 0, 'h200);
    chk("call2_cnt", 32'(bus.ras_count), 32'd2);
    drive("ret2", 0, 0, 0, 0, 1, 0, 0);
    chk("ret2_pc", 32'(bus.prog_ctr), 32'h106);
    drive("ret1", 0, 0, 0, 0, 1, 0, 0);
    chk("ret1_pc", 32'(bus.prog_ctr), 32'h021);

    // Overflow then underflow.
    jmp('h001);
    for (int i = 2; i <= 6; i++) drive("ocall", 0, 0, 0, 1, 0, 0, i);
    chk("ovf_flag", 32'(bus.ras_overflow), 32'd1);
    chk("ovf_cnt", 32'(bus.ras_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      drive("oret", 0, 0, 0, 0, 1, 0, 0);
      chk("oret_pc", 32'(bus.prog_ctr), 32'(exp_ret[i]));
    end
    drive("uret", 0, 0, 0, 0, 1, 0, 0);
    chk("unf_flag", 32'(bus.ras_underflow), 32'd1);
    chk("unf_pc", 32'(bus.prog_ctr), 32'h004);
    do_reset("rst2");

    // Priority and stall.
    jmp('h040);
    drive("pcall", 0, 0, 0, 1, 0, 0, 'h300);
    drive("prio", 0, 1, 0, 1, 1, 0, 'h555);
    chk("prio_pc", 32'(bus.prog_ctr), 32'h041);
    drive("stall", 1, 0, 0, 1, 0, 1, 'h777);
    chk("stall_pc", 32'(bus.prog_ctr), 32'h041);

    // Halt freezes everything until reset.
    jmp('h030);
    drive("halt", 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) begin
      drive("hold", 0, 1, 1, 1, 1, 0, int'($urandom_range(0, M - 1)));
      chk("hold_pc", 32'(bus.prog_ctr), 32'h030);
    end
    do_reset("rst3");

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      drive("rnd",
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 79) == 0,
            int'($urandom_range(0, M - 1)));
      if (m_halt && $urandom_range(0, 7) == 0) do_reset("rrst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
